spring_step_sequencer: RTL
==========================

# spring_step_sequencer

Time-multiplexed Euler-step engine for the two-mass, three-spring (linear plus cubic) oscillator. It shares a single 18x18 signed 2.16 multiplier across the 14 products each step needs, sequenced by an FSM. The integration equations and state update are identical to the fully parallel solver. It sits between the HPS/PIO parameter registers and the display sampler, and trades multiplier count for 16 cycles per step.

## Interface

- CNT_W, 32, width of the completed-step counter
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-low; loads initial state
- k1, k13, k2, k23, km, km3, D1, D2  in  18 each  signed 2.16 coefficients
- init_x1, init_x2, init_v1, init_v2  in  18 each  signed 2.16 initial state
- dt  in  4  time step as an arithmetic right-shift count
- step_req  in  1  request one Euler step
- run  in  1  free-run: issue steps back to back
- load  in  1  reload initial state (honoured in IDLE only)
- ready  out  1  high in IDLE; step_req accepted when ready=1
- step_done  out  1  one-cycle pulse when new state is visible
- x1, x2, v1, v2  out  18 each  signed 2.16 state
- step_count  out  CNT_W  steps completed since reset/load

## Operation

- States: IDLE, MUL (slot 0..13), UPDATE.
- IDLE: if load=1, set x/v to init_*, clear step_count, and stay in IDLE (load wins over step_req/run). Else if step_req|run, accept the step. On accept, latch all 8 coefficients and dt into shadow registers, enter MUL slot 0.
- Operands are computed from the current x/v with 18-bit wrap: a = x1 + 65535, b = 65536 - x2, d = x2 - x1.
- Multiply: 36-bit signed product p; result = {p[35], p[32:16]}. The high-order overflow is discarded silently, with no saturation.
- Slot order, one product per cycle, each registered into its own product register:
  - slots 0-3: k1·a, a·a, (a²)·a, k13·a³
  - slots 4-7: k2·b, b·b, (b²)·b, k23·b³
  - slots 8-11: km·d, d·d, (d²)·d, km3·d³
  - slots 12-13: v1·D1, v2·D2
- UPDATE: sp1 = k1a + k13a³; sp2 = k2b + k23b³; spm = kmd + km3d³.
  - f1 = -sp1 - v1D1 + spm; f2 = sp2 - v2D2 - spm (18-bit wrap).
  - All four registers update at the same edge, using the old v: x1 += v1>>>dt, x2 += v2>>>dt, v1 += f1>>>dt, v2 += f2>>>dt.
  - step_count increments, wrapping at 2^CNT_W.
  - Then return to IDLE.
- x/v are not modified during MUL. Only UPDATE or load/reset writes them.
- Coefficient or dt changes during a step have no effect until the next accept.
- step_req while ready=0 is ignored, not queued.

## Timing

- Reset (reset=0 at an edge):
  - x/v = init_*, step_count = 0, state = IDLE.
  - ready = 1 from the first cycle after reset; step_done = 0.
  - A step in progress is aborted and its products are discarded.
- Step accepted at edge N. MUL slots occupy edges N+1..N+14. UPDATE writes x/v/step_count at edge N+15.
- step_done = 1 and ready = 1 during the cycle after edge N+15. x/v hold their new values in that same cycle.
- Throughput: one step per 16 cycles with run=1. Next accept occurs at edge N+16.
- ready = 0 from the cycle after edge N through the cycle ending at edge N+15.

## Test plan

- Reset, then one step:
  - Stimulus: k1=k2=km=65536, k13=k23=km3=0, D1=D2=655, dt=9, x1=0, x2=42598, v=0.
  - Required: after step_done, x1=0, x2=42598, v1=-45, v2=-39, step_count=1.
- Latency: pulse step_req for one cycle at edge N.
  - Required: ready=0 for 15 cycles; step_done pulse exactly once, after edge N+15; a second step_req during busy is ignored (step_count=1).
- Free-run: run=1 for 160 cycles from IDLE.
  - Required: step_count=10; x1/x2 match a bit-exact golden model of the parallel Euler equations every step.
- Coefficient shadowing: change k1 to 0 at edge N+5 of a step.
  - Required: that step uses k1=65536; the next step uses 0.
- Reset mid-step: assert reset at edge N+7.
  - Required: x/v = init_* the next cycle, step_count=0, no step_done pulse, ready=1.
- Load priority: load=1 and step_req=1 together in IDLE.
  - Required: state reloaded, no step started, step_count=0.

Source files
------------

// File: rtl/spring_step_sequencer.sv
// Two-mass, three-spring Euler stepper sharing one 18x18 multiplier.
// Fourteen products per step are sequenced over MUL slots, then applied in UPDATE.
module spring_step_sequencer #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [17:0]      k1,
   input  logic [17:0]      k13,
   input  logic [17:0]      k2,
   input  logic [17:0]      k23,
   input  logic [17:0]      km,
   input  logic [17:0]      km3,
   input  logic [17:0]      D1,
   input  logic [17:0]      D2,
   input  logic [17:0]      init_x1,
   input  logic [17:0]      init_x2,
   input  logic [17:0]      init_v1,
   input  logic [17:0]      init_v2,
   input  logic [3:0]       dt,
   input  logic             step_req,
   input  logic             run,
   input  logic             load,
   output logic             ready,
   output logic             step_done,
   output logic [17:0]      x1,
   output logic [17:0]      x2,
   output logic [17:0]      v1,
   output logic [17:0]      v2,
   output logic [CNT_W-1:0] step_count
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_UPD
   } state_e;

   state_e           state_q, state_d;
   logic [3:0]       slot_q, slot_d;
   logic             accept, reload, update;
   logic             done_q;
   logic [17:0]      x1_q, x2_q, v1_q, v2_q;
   logic [CNT_W-1:0] cnt_q;

   logic [17:0] k1_q, k13_q, k2_q, k23_q;
   logic [17:0] km_q, km3_q, d1_q, d2_q;
   logic [3:0]  dt_q;
   logic [17:0] prod_q [14];

   logic [17:0]        op_a, op_b, op_d;
   logic [17:0]        op_x, op_y;
   logic signed [35:0] p;
   logic [17:0]        mul_r;

   assign op_a = x1_q + 18'd65535;
   assign op_b = 18'd65536 - x2_q;
   assign op_d = x2_q - x1_q;

   always_comb begin
      op_x = '0;
      op_y = '0;
      case (slot_q)
         4'd0:  begin op_x = k1_q;      op_y = op_a;      end
         4'd1:  begin op_x = op_a;      op_y = op_a;      end
         4'd2:  begin op_x = prod_q[1]; op_y = op_a;      end
         4'd3:  begin op_x = k13_q;     op_y = prod_q[2]; end
         4'd4:  begin op_x = k2_q;      op_y = op_b;      end
         4'd5:  begin op_x = op_b;      op_y = op_b;      end
         4'd6:  begin op_x = prod_q[5]; op_y = op_b;      end
         4'd7:  begin op_x = k23_q;     op_y = prod_q[6]; end
         4'd8:  begin op_x = km_q;      op_y = op_d;      end
         4'd9:  begin op_x = op_d;      op_y = op_d;      end
         4'd10: begin op_x = prod_q[9]; op_y = op_d;      end
         4'd11: begin op_x = km3_q;     op_y = prod_q[10]; end
         4'd12: begin op_x = v1_q;      op_y = d1_q;      end
         4'd13: begin op_x = v2_q;      op_y = d2_q;      end
         default: ;
      endcase
   end

   // 2.16 x 2.16 -> keep sign plus the 17 bits aligned to 2.16; overflow wraps
   assign p     = $signed(op_x) * $signed(op_y);
   assign mul_r = {p[35], 17'(p >> 16)};

   logic [17:0]        sp1, sp2, spm, f1, f2;
   logic signed [17:0] dx1, dx2, dv1, dv2;

   assign sp1 = prod_q[0] + prod_q[3];
   assign sp2 = prod_q[4] + prod_q[7];
   assign spm = prod_q[8] + prod_q[11];
   assign f1  = spm - sp1 - prod_q[12];
   assign f2  = sp2 - prod_q[13] - spm;
   assign dx1 = $signed(v1_q) >>> dt_q;
   assign dx2 = $signed(v2_q) >>> dt_q;
   assign dv1 = $signed(f1) >>> dt_q;
   assign dv2 = $signed(f2) >>> dt_q;

   always_comb begin
      state_d = state_q;
      slot_d  = slot_q;
      accept  = 1'b0;
      reload  = 1'b0;
      update  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (load) begin
               reload = 1'b1;
            end else if (step_req || run) begin
               accept  = 1'b1;
               state_d = S_MUL;
               slot_d  = 4'd0;
            end
         end
         S_MUL: begin
            slot_d = slot_q + 4'd1;
            if (slot_q == 4'd13) state_d = S_UPD;
         end
         S_UPD: begin
            update  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         slot_q  <= '0;
         done_q  <= 1'b0;
         x1_q    <= init_x1;
         x2_q    <= init_x2;
         v1_q    <= init_v1;
         v2_q    <= init_v2;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         slot_q  <= slot_d;
         done_q  <= update;
         if (reload) begin
            x1_q  <= init_x1;
            x2_q  <= init_x2;
            v1_q  <= init_v1;
            v2_q  <= init_v2;
            cnt_q <= '0;
         end else if (update) begin
            x1_q  <= x1_q + dx1;
            x2_q  <= x2_q + dx2;
            v1_q  <= v1_q + dv1;
            v2_q  <= v2_q + dv2;
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   // Shadow coefficients and products need no reset: only read after refill
   always_ff @(posedge clk) begin
      if (accept) begin
         k1_q  <= k1;
         k13_q <= k13;
         k2_q  <= k2;
         k23_q <= k23;
         km_q  <= km;
         km3_q <= km3;
         d1_q  <= D1;
         d2_q  <= D2;
         dt_q  <= dt;
      end
      if (state_q == S_MUL) begin
         for (int i = 0; i < 14; i++) begin
            if (slot_q == 4'(i)) prod_q[i] <= mul_r;
         end
      end
   end

   assign ready      = (state_q == S_IDLE);
   assign step_done  = done_q;
   assign x1         = x1_q;
   assign x2         = x2_q;
   assign v1         = v1_q;
   assign v2         = v2_q;
   assign step_count = cnt_q;

endmodule
